mem_stage: RTL and testbench



---
 rtl/mem_stage_if.sv | 30 +++
 rtl/mem_stage.sv | 130 +++++++++++++
 tb/tb_mem_stage.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_stage_if.sv
// E/M boundary of the memory stage: execute-side inputs plus stall/flush in, registered M-side results out.
// Combinational bundle; flow control is the stall/flush pair carried here.
interface mem_stage_if;
  logic        stall;
  logic        flush;
  logic [31:0] E_ALUResult;
  logic [31:0] E_mb;
  logic [4:0]  E_mrd;
  logic [3:0]  E_BE;
  logic [5:0]  E_op;
  logic        E_RegWrite;
  logic [31:0] E_PC8;
  logic [31:0] M_ALUResult;
  logic [4:0]  M_mrd;
  logic        M_RegWrite;
  logic [5:0]  M_op;
  logic [31:0] M_PC8;
  logic [31:0] M_RDData;
  logic [31:0] M_FwdData;
  logic        M_AdErr;

  modport master (
    output stall, flush, E_ALUResult, E_mb, E_mrd, E_BE, E_op, E_RegWrite, E_PC8,
    input  M_ALUResult, M_mrd, M_RegWrite, M_op, M_PC8, M_RDData, M_FwdData, M_AdErr
  );
  modport slave (
    input  stall, flush, E_ALUResult, E_mb, E_mrd, E_BE, E_op, E_RegWrite, E_PC8,
    output M_ALUResult, M_mrd, M_RegWrite, M_op, M_PC8, M_RDData, M_FwdData, M_AdErr
  );
endinterface

// File: rtl/mem_stage.sv
// MIPS memory stage: E/M register, byte-enabled data memory, load extension; one cycle E_* to M_*, load data combinational.
// stall holds the register and commits a held store once; flush overrides stall. MEM_ADDR_CHECK_EN enables alignment traps.
module mem_stage #(
  parameter int DM_WORDS = 2048,
  parameter int DM_AW    = 11
) (
  input logic        clk,
  input logic        rst,
  mem_stage_if.slave bus
);
  localparam logic [5:0] OP_JAL = 6'h03;
  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SW  = 6'h2B;

  typedef struct packed {
    logic [31:0] alu;
    logic [31:0] mb;
    logic [4:0]  mrd;
    logic [3:0]  be;
    logic [5:0]  op;
    logic        regwrite;
    logic [31:0] pc8;
  } em_t;

  em_t                 em;
  em_t                 em_in;
  logic                committed;
  logic [31:0]         mem [DM_WORDS];
  logic [DM_WORDS-1:0] word_vld;
  logic [DM_AW-1:0]    widx;
  logic [31:0]         word;
  logic [31:0]         lane_dat;
  logic [31:0]         merged;
  logic [31:0]         rd_dat;
  logic [7:0]          rd_byte;
  logic [15:0]         rd_half;
  logic                is_store;
  logic                ad_err;
  logic                do_write;

  assign em_in = '{alu: bus.E_ALUResult, mb: bus.E_mb, mrd: bus.E_mrd, be: bus.E_BE,
                   op: bus.E_op, regwrite: bus.E_RegWrite, pc8: bus.E_PC8};

  // Reset clears word_vld in one cycle; an unwritten word reads as zero.
  assign widx     = em.alu[DM_AW+1:2];
  assign word     = word_vld[widx] ? mem[widx] : 32'h0;
  assign is_store = (em.op == OP_SB) || (em.op == OP_SH) || (em.op == OP_SW);

`ifdef MEM_ADDR_CHECK_EN
  always_comb begin
    ad_err = 1'b0;
    case (em.op)
      OP_LW, OP_SW:         ad_err = (em.alu[1:0] != 2'b00);
      OP_LH, OP_LHU, OP_SH: ad_err = em.alu[0];
      default:              ad_err = 1'b0;
    endcase
  end
`else
  assign ad_err = 1'b0;
`endif

  assign do_write = is_store && !committed && !ad_err;

  always_comb begin
    lane_dat = em.mb;
    case (em.op)
      OP_SB:   lane_dat = {4{em.mb[7:0]}};
      OP_SH:   lane_dat = {2{em.mb[15:0]}};
      default: lane_dat = em.mb;
    endcase
    merged = word;
    for (int i = 0; i < 4; i++) begin
      if (em.be[i]) merged[8*i +: 8] = lane_dat[8*i +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      em        <= '0;
      committed <= 1'b0;
      word_vld  <= '0;
    end else begin
      if (do_write) word_vld[widx] <= 1'b1;
      if (bus.flush) begin
        em        <= '0;
        committed <= 1'b0;
      end else if (bus.stall) begin
        committed <= committed | is_store;
      end else begin
        em        <= em_in;
        committed <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && do_write) mem[widx] <= merged;
  end

  assign rd_byte = word[{em.alu[1:0], 3'b000} +: 8];
  assign rd_half = em.alu[1] ? word[31:16] : word[15:0];

  always_comb begin
    rd_dat = 32'h0;
    case (em.op)
      OP_LW:   rd_dat = word;
      OP_LB:   rd_dat = {{24{rd_byte[7]}}, rd_byte};
      OP_LBU:  rd_dat = {24'h0, rd_byte};
      OP_LH:   rd_dat = {{16{rd_half[15]}}, rd_half};
      OP_LHU:  rd_dat = {16'h0, rd_half};
      default: rd_dat = 32'h0;
    endcase
    if (ad_err) rd_dat = 32'h0;
  end

  assign bus.M_ALUResult = em.alu;
  assign bus.M_mrd       = em.mrd;
  assign bus.M_RegWrite  = em.regwrite;
  assign bus.M_op        = em.op;
  assign bus.M_PC8       = em.pc8;
  assign bus.M_RDData    = rd_dat;
  assign bus.M_FwdData   = (em.op == OP_JAL) ? em.pc8 : em.alu;
  assign bus.M_AdErr     = ad_err;
endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: byte-array reference model compared every cycle, plus directed literal expectations.
// Honours MEM_ADDR_CHECK_EN for the alignment-trap expectations.
module tb_mem_stage;
  localparam logic [5:0] OP_NOP = 6'h00;
  localparam logic [5:0] OP_JAL = 6'h03;
  localparam logic [5:0] OP_ORI = 6'h0D;
  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SW  = 6'h2B;

  logic clk = 1'b0;
  logic rst = 1'b1;
  mem_stage_if bus();

  mem_stage #(.DM_WORDS(2048), .DM_AW(11)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %08h, expected %08h at %0t", name, act, exp, $time);
  endtask

  // Reference model: memory as a flat 8 KB byte array, instruction identity by sequence number.
  logic [7:0]  mm [8192];
  logic [31:0] x_alu, x_mb, x_pc8;
  logic [4:0]  x_mrd;
  logic [3:0]  x_be;
  logic [5:0]  x_op;
  logic        x_rw;
  int          x_seq    = 0;
  int          seq_ctr  = 0;
  int          done_seq = -1;
  bit          started  = 1'b0;

  function automatic logic x_aderr();
`ifdef MEM_ADDR_CHECK_EN
    if (x_op == OP_LW || x_op == OP_SW) return x_alu[1:0] != 2'b00;
    if (x_op == OP_LH || x_op == OP_LHU || x_op == OP_SH) return x_alu[0];
`endif
    return 1'b0;
  endfunction

  function automatic logic [31:0] model_load();
    int a, b, h;
    logic [31:0] w;
    logic [15:0] hv;
    a  = int'(x_alu[12:0]);
    b  = a & ~3;
    h  = a & ~1;
    w  = {mm[b+3], mm[b+2], mm[b+1], mm[b]};
    hv = {mm[h+1], mm[h]};
    if (x_aderr()) return 32'h0;
    case (x_op)
      OP_LW:   return w;
      OP_LB:   return {{24{mm[a][7]}}, mm[a]};
      OP_LBU:  return {24'h0, mm[a]};
      OP_LH:   return {{16{hv[15]}}, hv};
      OP_LHU:  return {16'h0, hv};
      default: return 32'h0;
    endcase
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      foreach (mm[i]) mm[i] = 8'h00;
      {x_alu, x_mb, x_pc8, x_mrd, x_be, x_op, x_rw} = '0;
      seq_ctr++;
      x_seq    = seq_ctr;
      done_seq = -1;
      started  = 1'b1;
    end else begin
      if ((x_op == OP_SB || x_op == OP_SH || x_op == OP_SW) && x_seq != done_seq && !x_aderr()) begin
        for (int i = 0; i < 4; i++) begin
          if (x_be[i]) begin
            if (x_op == OP_SB)      mm[int'(x_alu[12:0] & 13'h1FFC) + i] = x_mb[7:0];
            else if (x_op == OP_SH) mm[int'(x_alu[12:0] & 13'h1FFC) + i] = x_mb[8*(i%2) +: 8];
            else                    mm[int'(x_alu[12:0] & 13'h1FFC) + i] = x_mb[8*i +: 8];
          end
        end
        done_seq = x_seq;
      end
      if (bus.flush) begin
        {x_alu, x_mb, x_pc8, x_mrd, x_be, x_op, x_rw} = '0;
        seq_ctr++;
        x_seq = seq_ctr;
      end else if (!bus.stall) begin
        x_alu = bus.E_ALUResult; x_mb = bus.E_mb;  x_pc8 = bus.E_PC8;
        x_mrd = bus.E_mrd;       x_be = bus.E_BE;  x_op  = bus.E_op;
        x_rw  = bus.E_RegWrite;
        seq_ctr++;
        x_seq = seq_ctr;
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("M_ALUResult", bus.M_ALUResult, x_alu);
      chk("M_mrd", 32'(bus.M_mrd), 32'(x_mrd));
      chk("M_RegWrite", 32'(bus.M_RegWrite), 32'(x_rw));
      chk("M_op", 32'(bus.M_op), 32'(x_op));
      chk("M_PC8", bus.M_PC8, x_pc8);
      chk("M_RDData", bus.M_RDData, model_load());
      chk("M_FwdData", bus.M_FwdData, (x_op == OP_JAL) ? x_pc8 : x_alu);
      chk("M_AdErr", 32'(bus.M_AdErr), 32'(x_aderr()));
    end
  end

  task automatic drive_all(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] mb,
                           input logic [3:0] be, input logic [4:0] mrd, input logic rw,
                           input logic [31:0] pc8, input logic s, input logic f);
    bus.E_op = op; bus.E_ALUResult = addr; bus.E_mb = mb; bus.E_BE = be;
    bus.E_mrd = mrd; bus.E_RegWrite = rw; bus.E_PC8 = pc8;
    bus.stall = s; bus.flush = f;
    @(posedge clk);
    #3;
  endtask

  task automatic drv(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] mb,
                     input logic [3:0] be, input logic s, input logic f);
    logic st;
    st = (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    drive_all(op, addr, mb, be, 5'd9, !st, addr + 32'h1000_0008, s, f);
  endtask

  logic [5:0] ops [11] = '{OP_NOP, OP_JAL, OP_ORI, OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW};

  initial begin
    rst = 1'b1;
    drv(OP_NOP, 0, 0, 0, 0, 0);
    drv(OP_NOP, 0, 0, 0, 0, 0);
    chk("reset M_op", 32'(bus.M_op), 32'h0);
    chk("reset M_ALUResult", bus.M_ALUResult, 32'h0);
    chk("reset M_PC8", bus.M_PC8, 32'h0);
    chk("reset M_AdErr", 32'(bus.M_AdErr), 32'h0);
    rst = 1'b0;

    drv(OP_SW, 32'h100, 32'h1234_5678, 4'hF, 0, 0);
    chk("sw M_ALUResult", bus.M_ALUResult, 32'h100);
    drv(OP_LW, 32'h100, 0, 4'h0, 0, 0);
    chk("lw 0x100", bus.M_RDData, 32'h1234_5678);

    drv(OP_SW, 32'h200, 32'h0, 4'hF, 0, 0);
    drv(OP_SB, 32'h201, 32'h80, 4'b0010, 0, 0);
    drv(OP_LW, 32'h200, 0, 4'h0, 0, 0);
    chk("lw after sb", bus.M_RDData, 32'h0000_8000);
    drv(OP_LB, 32'h201, 0, 4'h0, 0, 0);
    chk("lb 0x201", bus.M_RDData, 32'hFFFF_FF80);
    drv(OP_LBU, 32'h201, 0, 4'h0, 0, 0);
    chk("lbu 0x201", bus.M_RDData, 32'h0000_0080);

    drv(OP_SH, 32'h302, 32'hBEEF, 4'b1100, 0, 0);
    drv(OP_LH, 32'h302, 0, 4'h0, 0, 0);
    chk("lh 0x302", bus.M_RDData, 32'hFFFF_BEEF);
    drv(OP_LHU, 32'h302, 0, 4'h0, 0, 0);
    chk("lhu 0x302", bus.M_RDData, 32'h0000_BEEF);
    drv(OP_LW, 32'h300, 0, 4'h0, 0, 0);
    chk("lw after sh", bus.M_RDData, 32'hBEEF_0000);

    drv(OP_JAL, 32'h55, 0, 4'h0, 0, 0);
    chk("jal forward", bus.M_FwdData, 32'h1000_005D);

    drv(OP_SW, 32'h10, 32'hAAAA_5555, 4'hF, 0, 0);
    for (int i = 0; i < 3; i++) begin
      drv(OP_LW, 32'h10, 0, 4'h0, 1, 0);
      chk("stall holds addr", bus.M_ALUResult, 32'h10);
      chk("stall holds op", 32'(bus.M_op), 32'(OP_SW));
    end
    drv(OP_LW, 32'h10, 0, 4'h0, 0, 0);
    chk("lw after stalled sw", bus.M_RDData, 32'hAAAA_5555);

    drv(OP_SW, 32'h20, 32'h7777_7777, 4'hF, 1, 1);
    chk("flush M_op", 32'(bus.M_op), 32'h0);
    chk("flush M_ALUResult", bus.M_ALUResult, 32'h0);
    chk("flush M_RegWrite", 32'(bus.M_RegWrite), 32'h0);
    drv(OP_LW, 32'h20, 0, 4'h0, 0, 0);
    chk("no write after flush", bus.M_RDData, 32'h0);

    drv(OP_SW, 32'h104, 32'hDEAD_BEEF, 4'hF, 0, 0);
    rst = 1'b1;
    drv(OP_NOP, 0, 0, 4'h0, 0, 0);
    chk("rst M_op", 32'(bus.M_op), 32'h0);
    chk("rst M_ALUResult", bus.M_ALUResult, 32'h0);
    rst = 1'b0;
    drv(OP_LW, 32'h104, 0, 4'h0, 0, 0);
    chk("sw under rst", bus.M_RDData, 32'h0);
    drv(OP_LW, 32'h100, 0, 4'h0, 0, 0);
    chk("mem cleared", bus.M_RDData, 32'h0);

    drv(OP_SW, 32'h100, 32'h1234_5678, 4'hF, 0, 0);
    drv(OP_LW, 32'h102, 0, 4'h0, 0, 0);
`ifdef MEM_ADDR_CHECK_EN
    chk("misaligned lw flag", 32'(bus.M_AdErr), 32'h1);
    chk("misaligned lw data", bus.M_RDData, 32'h0);
`else
    chk("misaligned lw flag", 32'(bus.M_AdErr), 32'h0);
    chk("misaligned lw data", bus.M_RDData, 32'h1234_5678);
`endif
    drv(OP_SH, 32'h301, 32'h1234, 4'b1100, 0, 0);
    drv(OP_LW, 32'h300, 0, 4'h0, 0, 0);
`ifdef MEM_ADDR_CHECK_EN
    chk("misaligned sh", bus.M_RDData, 32'h0);
`else
    chk("misaligned sh", bus.M_RDData, 32'h1234_0000);
`endif

    for (int n = 0; n < 3000; n++) begin
      logic [5:0]  op;
      logic [31:0] addr;
      logic [3:0]  be;
      op   = ops[$urandom_range(0, 10)];
      addr = ($urandom & 32'hFFFF_E000) | 32'($urandom_range(0, 63));
      case (op)
        OP_SB:   be = 4'b0001 << addr[1:0];
        OP_SH:   be = addr[1] ? 4'b1100 : 4'b0011;
        OP_SW:   be = 4'hF;
        default: be = 4'($urandom);
      endcase
      if ($urandom_range(0, 9) == 0) be = 4'($urandom);
      rst = ($urandom_range(0, 199) == 0);
      drive_all(op, addr, $urandom, be, 5'($urandom), 1'($urandom), $urandom,
                $urandom_range(0, 99) < 20, $urandom_range(0, 99) < 8);
    end
    rst = 1'b0;
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
